// File: rtl/alu_muldiv_seq_if.sv
// Issue-side and ALU-side signal bundle for the multiply/divide sequencer.
// slave = the sequencer; master = decode/issue logic plus the shared ALU.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic             alu_sub;
  logic             alu_op1;
  logic             alu_op2;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_cout;

  modport slave (
    input  start, op, opa, opb, alu_sum, alu_cout,
    output busy, done, result_hi, result_lo, div_by_zero,
           alu_a, alu_b, alu_cin, alu_sub, alu_op1, alu_op2
  );

  modport master (
    output start, op, opa, opb, alu_sum, alu_cout,
    input  busy, done, result_hi, result_lo, div_by_zero,
           alu_a, alu_b, alu_cin, alu_sub, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer that borrows the shared ripple ALU
// for one add or subtract per cycle; 32 iterations per operation.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_muldiv_seq_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_q, state_d;
  // acc holds H (multiply) or R (divide); lo holds L or Q; m holds M or D.
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   alu_a_c, alu_b_c;
  logic               alu_sub_c;
  logic [WIDTH:0]     t_ext;
  logic               take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    alu_a_c   = '0;
    alu_b_c   = '0;
    alu_sub_c = 1'b0;
    take      = 1'b0;
    t_ext     = {acc_q, lo_q[WIDTH-1]};

    case (state_q)
      S_IDLE: begin
        // The done cycle is still IDLE, but a start there is dropped.
        if (bus.start && !done_q) begin
          cnt_d = '0;
          if (!bus.op) begin
            acc_d   = '0;
            lo_d    = bus.opb;
            m_d     = bus.opa;
            dbz_d   = 1'b0;
            state_d = S_MUL;
          end else if (bus.opb != '0) begin
            acc_d   = '0;
            lo_d    = bus.opa;
            m_d     = bus.opb;
            dbz_d   = 1'b0;
            state_d = S_DIV;
          end else begin
            res_lo_d = '1;
            res_hi_d = bus.opa;
            dbz_d    = 1'b1;
            state_d  = S_FIN;
          end
        end
      end
      S_MUL: begin
        alu_a_c = acc_q;
        alu_b_c = m_q;
        if (lo_q[0]) {acc_d, lo_d} = {bus.alu_cout, bus.alu_sum, lo_q[WIDTH-1:1]};
        else         {acc_d, lo_d} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIN;
      end
      S_DIV: begin
        alu_a_c   = t_ext[WIDTH-1:0];
        alu_b_c   = m_q;
        alu_sub_c = 1'b1;
        // No borrow, or the shifted-out bit alone makes T >= D.
        take  = t_ext[WIDTH] | bus.alu_cout;
        acc_d = take ? bus.alu_sum : t_ext[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIN;
      end
      S_FIN: begin
        done_d = 1'b1;
        if (!dbz_q) begin
          res_hi_d = acc_q;
          res_lo_d = lo_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done        = done_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.alu_a       = alu_a_c;
  assign bus.alu_b       = alu_b_c;
  assign bus.alu_sub     = alu_sub_c;
  assign bus.alu_cin     = alu_sub_c;
  assign bus.alu_op1     = 1'b0;
  assign bus.alu_op2     = 1'b1;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboarded random bench for alu_muldiv_seq with a behavioural ALU attached.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32)) bus();

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shared ripple ALU: AND / SUM / OR with bitwise-replicated sub.
  always_comb begin
    logic [31:0] bx;
    logic [32:0] s;
    bx = bus.alu_b ^ {32{bus.alu_sub}};
    s  = {1'b0, bus.alu_a} + {1'b0, bx} + {32'd0, bus.alu_cin};
    bus.alu_cout = s[32];
    case ({bus.alu_op1, bus.alu_op2})
      2'b00:   bus.alu_sum = bus.alu_a & bx;
      2'b10:   bus.alu_sum = bus.alu_a | bx;
      default: bus.alu_sum = s[31:0];
    endcase
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(bit op, logic [31:0] a, logic [31:0] b, int k);
    exp_t e;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.due = k + 33;
    if (!op) begin
      p    = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.due = k + 1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result_hi",   64'(bus.result_hi),   64'(e.hi));
        chk("result_lo",   64'(bus.result_lo),   64'(e.lo));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        chk("done_cycle",  64'(cyc),             64'(e.due));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_op(bit op, logic [31:0] a, logic [31:0] b);
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    sb.push_back(model(op, a, b, cyc));
    bus.opa = $urandom; bus.opb = $urandom;
    @(negedge clk);
    chk("busy_after_start", 64'(bus.busy), (op && b == 32'd0) ? 64'd0 : 64'd1);
  endtask

  task automatic chk_reset_state();
    chk("rst_busy",  64'(bus.busy),        64'd0);
    chk("rst_done",  64'(bus.done),        64'd0);
    chk("rst_dbz",   64'(bus.div_by_zero), 64'd0);
    chk("rst_hi",    64'(bus.result_hi),   64'd0);
    chk("rst_lo",    64'(bus.result_lo),   64'd0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    chk("rst_alu_ctl", 64'({bus.alu_cin, bus.alu_sub, bus.alu_op1, bus.alu_op2}), 64'b0001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.opa = '0; bus.opb = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state();

    // Directed cases
    do_op(1'b0, 32'd7, 32'd6);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(1'b1, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op(1'b1, 32'd55, 32'd0);
    do_op(1'b0, 32'd3, 32'd3);

    // Abort: divide in flight, ignored start at +10, reset at +20
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b1; bus.opa = 32'd1000; bus.opb = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.start = 1'b1; bus.opa = 32'd5; bus.opb = 32'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state();
    repeat (40) @(posedge clk);
    do_op(1'b1, 32'd9, 32'd3);

    // Start held high across three back-to-back multiplies
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.opa = 32'd2; bus.opb = 32'd3;
    @(posedge clk); #1;
    sb.push_back(model(1'b0, 32'd2, 32'd3, cyc));
    bus.opa = 32'd4; bus.opb = 32'd5;
    repeat (35) @(posedge clk); #1;
    sb.push_back(model(1'b0, 32'd4, 32'd5, cyc));
    bus.opa = 32'd6; bus.opb = 32'd7;
    repeat (35) @(posedge clk); #1;
    sb.push_back(model(1'b0, 32'd6, 32'd7, cyc));
    bus.start = 1'b0;

    // Random mix including zero divisors, small divisors and large operands
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit op;
      op = $urandom_range(0, 1);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      do_op(op, a, b);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
